ex_muldiv_stage: RTL and testbench

- EX-stage datapath block that sits directly downstream of the forwarding unit.
- It consumes the 2-bit ForwardA/ForwardB selects to build the forwarded EX operands.
- It runs a multi-cycle iterative multiply/divide unit that owns the HI/LO registers.
- It raises a pipeline stall while a new mult/div/mthi/mtlo/mfhi/mflo in EX collides with an in-flight operation.

---
 rtl/ex_muldiv_stage.sv | 158 +++++++++++++++
 tb/tb_ex_muldiv_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_stage.sv
// EX-stage operand forwarding plus an iterative mult/div unit that owns HI/LO.
// Results land DATA_W+1 edges after acceptance; md_stall holds new md/HI-LO users while busy.
module ex_muldiv_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        ForwardA,
   input  logic [1:0]        ForwardB,
   input  logic [DATA_W-1:0] rs_data_inIDEX,
   input  logic [DATA_W-1:0] rt_data_inIDEX,
   input  logic [DATA_W-1:0] alu_result_inEXMEM,
   input  logic [DATA_W-1:0] wb_data_inMEMWB,
   input  logic [2:0]        md_op_inIDEX,
   input  logic              md_read_inIDEX,
   input  logic              flush_inIDEX,
   output logic [DATA_W-1:0] opA,
   output logic [DATA_W-1:0] opB,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              md_busy,
   output logic              md_stall
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_hi, r_lo;
   logic [DATA_W-1:0]   r_acc, r_q, r_b, r_dvd;
   logic                r_is_div, r_neg_q, r_neg_r, r_busy;

   logic                w_accept, w_signed, w_md_user;
   logic [DATA_W:0]     w_abs_a, w_abs_b;
   logic [DATA_W:0]     w_msum, w_trial;
   logic [2*DATA_W-1:0] w_prod, w_prod_fix;

   always_comb begin
      case (ForwardA)
         2'b01:   opA = alu_result_inEXMEM;
         2'b10:   opA = wb_data_inMEMWB;
         default: opA = rs_data_inIDEX;
      endcase
      case (ForwardB)
         2'b01:   opB = alu_result_inEXMEM;
         2'b10:   opB = wb_data_inMEMWB;
         default: opB = rt_data_inIDEX;
      endcase
   end

   assign w_accept  = (r_state == IDLE) && !flush_inIDEX &&
                      (md_op_inIDEX >= OP_MULT) && (md_op_inIDEX <= OP_DIVU);
   assign w_signed  = (md_op_inIDEX == OP_MULT) || (md_op_inIDEX == OP_DIV);
   assign w_md_user = ((md_op_inIDEX != 3'b000) && (md_op_inIDEX != 3'b111)) || md_read_inIDEX;

   // One extra bit so the magnitude of the most negative value is exact.
   assign w_abs_a = (w_signed && opA[DATA_W-1]) ? ({1'b0, ~opA} + {{DATA_W{1'b0}}, 1'b1})
                                                 : {1'b0, opA};
   assign w_abs_b = (w_signed && opB[DATA_W-1]) ? ({1'b0, ~opB} + {{DATA_W{1'b0}}, 1'b1})
                                                 : {1'b0, opB};

   assign w_msum     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(DATA_W+1){1'b0}});
   assign w_trial    = {r_acc, r_q[DATA_W-1]} - {1'b0, r_b};
   assign w_prod     = {r_acc, r_q};
   assign w_prod_fix = r_neg_q ? (~w_prod + {{(2*DATA_W-1){1'b0}}, 1'b1}) : w_prod;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_b      <= '0;
         r_dvd    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state  <= CALC;
                  r_busy   <= 1'b1;
                  r_cnt    <= CNT_W'(DATA_W);
                  r_is_div <= (md_op_inIDEX == OP_DIV) || (md_op_inIDEX == OP_DIVU);
                  r_neg_q  <= w_signed && (opA[DATA_W-1] ^ opB[DATA_W-1]);
                  r_neg_r  <= w_signed && opA[DATA_W-1];
                  r_dvd    <= opA;
                  r_acc    <= '0;
                  // Divide shifts the dividend out of r_q; multiply shifts the multiplier out.
                  if ((md_op_inIDEX == OP_DIV) || (md_op_inIDEX == OP_DIVU)) begin
                     r_q <= w_abs_a[DATA_W-1:0];
                     r_b <= w_abs_b[DATA_W-1:0];
                  end else begin
                     r_q <= w_abs_b[DATA_W-1:0];
                     r_b <= w_abs_a[DATA_W-1:0];
                  end
               end else if (!flush_inIDEX && md_op_inIDEX == OP_MTHI) begin
                  r_hi <= opA;
               end else if (!flush_inIDEX && md_op_inIDEX == OP_MTLO) begin
                  r_lo <= opA;
               end
            end
            CALC: begin
               if (r_is_div) begin
                  if (!w_trial[DATA_W]) begin
                     r_acc <= w_trial[DATA_W-1:0];
                     r_q   <= {r_q[DATA_W-2:0], 1'b1};
                  end else begin
                     r_acc <= {r_acc[DATA_W-2:0], r_q[DATA_W-1]};
                     r_q   <= {r_q[DATA_W-2:0], 1'b0};
                  end
               end else begin
                  r_acc <= w_msum[DATA_W:1];
                  r_q   <= {w_msum[0], r_q[DATA_W-1:1]};
               end
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) r_state <= DONE;
            end
            DONE: begin
               if (!r_is_div) begin
                  r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
                  r_lo <= w_prod_fix[DATA_W-1:0];
               end else if (r_b == '0) begin
                  r_hi <= r_dvd;
                  r_lo <= '1;
               end else begin
                  r_hi <= r_neg_r ? (~r_acc + {{(DATA_W-1){1'b0}}, 1'b1}) : r_acc;
                  r_lo <= r_neg_q ? (~r_q + {{(DATA_W-1){1'b0}}, 1'b1}) : r_q;
               end
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign hi       = r_hi;
   assign lo       = r_lo;
   assign md_busy  = r_busy;
   assign md_stall = r_busy && !flush_inIDEX && w_md_user;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed bench for ex_muldiv_stage: forwarding muxes, mult/div results, latency, stall and reset.
module tb_ex_muldiv_stage;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   ForwardA, ForwardB;
   logic [W-1:0] rs_data_inIDEX, rt_data_inIDEX, alu_result_inEXMEM, wb_data_inMEMWB;
   logic [2:0]   md_op_inIDEX;
   logic         md_read_inIDEX, flush_inIDEX;
   logic [W-1:0] opA, opB, hi, lo;
   logic         md_busy, md_stall;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ex_muldiv_stage #(.DATA_W(W), .CNT_W(6)) u_dut (
      .clk                (clk),
      .rst                (rst),
      .ForwardA           (ForwardA),
      .ForwardB           (ForwardB),
      .rs_data_inIDEX     (rs_data_inIDEX),
      .rt_data_inIDEX     (rt_data_inIDEX),
      .alu_result_inEXMEM (alu_result_inEXMEM),
      .wb_data_inMEMWB    (wb_data_inMEMWB),
      .md_op_inIDEX       (md_op_inIDEX),
      .md_read_inIDEX     (md_read_inIDEX),
      .flush_inIDEX       (flush_inIDEX),
      .opA                (opA),
      .opB                (opB),
      .hi                 (hi),
      .lo                 (lo),
      .md_busy            (md_busy),
      .md_stall           (md_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      ForwardA       = 2'b00;
      ForwardB       = 2'b00;
      rs_data_inIDEX = a;
      rt_data_inIDEX = b;
      md_op_inIDEX   = op;
      step();
      md_op_inIDEX   = 3'b000;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (md_busy && cyc < 100) begin
         cyc++;
         step();
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo);
      int cyc;
      issue(op, a, b);
      wait_idle(cyc);
      chk({tag, "_busy_cycles"}, cyc, 32'd33);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      int cyc;
      rst = 1'b1;
      ForwardA = 2'b00; ForwardB = 2'b00;
      rs_data_inIDEX = '0; rt_data_inIDEX = '0;
      alu_result_inEXMEM = '0; wb_data_inMEMWB = '0;
      md_op_inIDEX = 3'b000; md_read_inIDEX = 1'b0; flush_inIDEX = 1'b0;
      step(); step();
      rst = 1'b0;
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      chk("reset_busy", 32'(md_busy), 32'd0);
      chk("reset_stall", 32'(md_stall), 32'd0);

      // Forwarding muxes
      rs_data_inIDEX = 32'h11; rt_data_inIDEX = 32'h22;
      alu_result_inEXMEM = 32'hAA; wb_data_inMEMWB = 32'hBB;
      ForwardA = 2'b01; ForwardB = 2'b10; #1;
      chk("fwd_a_exmem", opA, 32'hAA);
      chk("fwd_b_memwb", opB, 32'hBB);
      ForwardA = 2'b11; ForwardB = 2'b00; #1;
      chk("fwd_a_11", opA, 32'h11);
      chk("fwd_b_00", opB, 32'h22);
      ForwardA = 2'b10; ForwardB = 2'b01; #1;
      chk("fwd_a_memwb", opA, 32'hBB);
      chk("fwd_b_exmem", opB, 32'hAA);

      run_op("mult_neg2x3", 3'b001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_op("div_m7d2", 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu_7d0", 3'b100, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
      run_op("div_minint", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
      run_op("divu_100d7", 3'b100, 32'd100, 32'd7, 32'd2, 32'd14);

      // mfhi right behind a multu is held until the result lands
      issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
      md_read_inIDEX = 1'b1; #1;
      chk("mfhi_stall_on", 32'(md_stall), 32'd1);
      cyc = 0;
      while (md_stall && cyc < 100) begin
         cyc++;
         step();
      end
      chk("mfhi_stall_cycles", cyc, 32'd33);
      chk("mfhi_busy_off", 32'(md_busy), 32'd0);
      chk("mfhi_hi", hi, 32'hFFFFFFFE);
      chk("mfhi_lo", lo, 32'h1);
      md_read_inIDEX = 1'b0;

      // mtlo behind a multu stalls, then overwrites lo
      issue(3'b010, 32'd3, 32'd5);
      md_op_inIDEX = 3'b110; rs_data_inIDEX = 32'h1234; #1;
      chk("mtlo_stall_on", 32'(md_stall), 32'd1);
      wait_idle(cyc);
      chk("mtlo_busy_cycles", cyc, 32'd33);
      chk("mtlo_stall_off", 32'(md_stall), 32'd0);
      chk("mtlo_op_lo", lo, 32'd15);
      step();
      md_op_inIDEX = 3'b000;
      chk("mtlo_lo_written", lo, 32'h1234);
      chk("mtlo_hi_kept", hi, 32'h0);

      // Same with the mtlo squashed: no stall, op result survives
      issue(3'b010, 32'd3, 32'd5);
      md_op_inIDEX = 3'b110; rs_data_inIDEX = 32'h1234; flush_inIDEX = 1'b1; #1;
      chk("flush_no_stall", 32'(md_stall), 32'd0);
      chk("flush_busy", 32'(md_busy), 32'd1);
      wait_idle(cyc);
      chk("flush_busy_cycles", cyc, 32'd33);
      step();
      chk("flush_lo_kept", lo, 32'd15);
      md_op_inIDEX = 3'b000; flush_inIDEX = 1'b0;

      // Reset in the middle of a divide
      issue(3'b011, 32'd100, 32'd7);
      repeat (9) step();
      chk("midrst_busy_before", 32'(md_busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_busy", 32'(md_busy), 32'd0);
      chk("midrst_hi", hi, 32'h0);
      chk("midrst_lo", lo, 32'h0);
      run_op("mult_after_rst", 3'b001, 32'd6, 32'd7, 32'h0, 32'd42);

      // Reset wins over a simultaneous op
      rst = 1'b1; md_op_inIDEX = 3'b001; rs_data_inIDEX = 32'd2; rt_data_inIDEX = 32'd3;
      step();
      rst = 1'b0; md_op_inIDEX = 3'b000;
      chk("rst_vs_op_busy", 32'(md_busy), 32'd0);
      step();
      chk("rst_vs_op_busy2", 32'(md_busy), 32'd0);

      // Reserved op, flushed op and mthi in IDLE
      issue(3'b111, 32'h55, 32'h66);
      chk("op111_busy", 32'(md_busy), 32'd0);
      chk("op111_lo", lo, 32'h0);
      flush_inIDEX = 1'b1;
      issue(3'b001, 32'd2, 32'd3);
      flush_inIDEX = 1'b0;
      chk("flushed_mult_busy", 32'(md_busy), 32'd0);
      md_read_inIDEX = 1'b1; #1;
      chk("idle_read_no_stall", 32'(md_stall), 32'd0);
      md_read_inIDEX = 1'b0;
      issue(3'b101, 32'hCAFE, 32'h0);
      chk("mthi_hi", hi, 32'hCAFE);
      chk("mthi_busy", 32'(md_busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
